// File: rtl/seq_det_pkg.sv
// Shared constants, mode encoding and sizing helper for the serial pattern detector.
package seq_det_pkg;

    // Reset configuration: reproduces the legacy 1011 detector.
    localparam int unsigned RST_MAX_LEN = 8;
    localparam logic [7:0]  RST_PATTERN = 8'h0B;
    localparam int unsigned RST_LEN     = 4;
    localparam int unsigned RST_CNT_W   = 16;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    // Width needed to hold a length value in 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: clear, else increment unless already at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlap select and match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = RST_MAX_LEN,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(RST_PATTERN),
    parameter int unsigned          DEF_LEN     = RST_LEN,
    parameter int unsigned          CNT_W       = RST_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          seq_in,
    input  logic                          in_valid,
    input  logic                          mode_ovl,
    input  logic                          cfg_load,
    input  logic [MAX_LEN-1:0]            cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]     cfg_len,
    input  logic                          cnt_clr,
    output logic                          detect_out,
    output logic [CNT_W-1:0]              match_count,
    output logic                          cfg_err
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    // Ones in the low l bit positions.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (LEN_W'(i) < l);
        end
        return m;
    endfunction

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [MAX_LEN-1:0] shreg_q,   shreg_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               cfg_err_d;

    logic [MAX_LEN-1:0] mask_c;
    logic [MAX_LEN-1:0] cfg_mask_c;
    logic [MAX_LEN:0]   window_c;
    logic [LEN_W:0]     fill_p1_c;
    logic               fill_ok_c;
    logic               cfg_ok_c;
    logic               match_c;

    // Match decode and next-state for config, history and fill level.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        shreg_d   = shreg_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;

        mask_c     = len_mask(len_q);
        cfg_mask_c = len_mask(cfg_len);
        window_c   = {shreg_q, seq_in};
        fill_p1_c  = {1'b0, fill_q} + (LEN_W+1)'(1);
        fill_ok_c  = (fill_p1_c >= {1'b0, len_q});
        cfg_ok_c   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        match_c    = in_valid && !cfg_load && fill_ok_c &&
                     ((window_c & {1'b0, mask_c}) == {1'b0, pattern_q & mask_c});

        if (cfg_load) begin
            // A load always consumes the cycle; the incoming bit is discarded.
            if (cfg_ok_c) begin
                pattern_d = cfg_pattern & cfg_mask_c;
                len_d     = cfg_len;
                shreg_d   = '0;
                fill_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            shreg_d = window_c[MAX_LEN-1:0];
            if (match_c && (mode_e'(mode_ovl) == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q  <= DEF_PATTERN;
            len_q      <= LEN_W'(DEF_LEN);
            shreg_q    <= '0;
            fill_q     <= '0;
            detect_out <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            shreg_q    <= shreg_d;
            fill_q     <= fill_d;
            detect_out <= match_c;
            cfg_err    <= cfg_err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (match_c),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param; a second instance uses a 2-bit counter.
module tb_seq_detector_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        seq_in;
    logic        in_valid;
    logic        mode_ovl;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cnt_clr;

    logic        det_a, err_a, det_b, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    seq_detector_param dut_a (
        .clk         (clk),
        .reset       (reset),
        .seq_in      (seq_in),
        .in_valid    (in_valid),
        .mode_ovl    (mode_ovl),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .detect_out  (det_a),
        .match_count (cnt_a),
        .cfg_err     (err_a)
    );

    seq_detector_param #(.CNT_W(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .seq_in      (seq_in),
        .in_valid    (in_valid),
        .mode_ovl    (mode_ovl),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .detect_out  (det_b),
        .match_count (cnt_b),
        .cfg_err     (err_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       b;
        logic       ovl;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       clr;
        logic       det;
        logic       err;
        int         cnt;
        int         cntb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic b, input logic ovl, input logic ld,
                       input logic [7:0] pat, input logic [3:0] len, input logic clr,
                       input logic det, input logic err, input int cnt, input int cntb);
        vec_t x;
        x.v = v; x.b = b; x.ovl = ovl; x.ld = ld; x.pat = pat; x.len = len; x.clr = clr;
        x.det = det; x.err = err; x.cnt = cnt; x.cntb = cntb;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic v, input logic b, input logic ovl, input logic ld,
                         input logic [7:0] pat, input logic [3:0] len, input logic clr);
        in_valid    = v;
        seq_in      = b;
        mode_ovl    = ovl;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = len;
        cnt_clr     = clr;
    endtask

    task automatic apply(input vec_t x, input int idx);
        drive(x.v, x.b, x.ovl, x.ld, x.pat, x.len, x.clr);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_det_a", idx), 32'(det_a), 32'(x.det));
        check($sformatf("v%0d_err_a", idx), 32'(err_a), 32'(x.err));
        check($sformatf("v%0d_cnt_a", idx), 32'(cnt_a), 32'(x.cnt));
        check($sformatf("v%0d_det_b", idx), 32'(det_b), 32'(x.det));
        check($sformatf("v%0d_cnt_b", idx), 32'(cnt_b), 32'(x.cntb));
    endtask

    task automatic step_bit(input logic b, input logic exp_det, input string name);
        drive(1'b1, b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check(name, 32'(det_a), 32'(exp_det));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_det",   32'(det_a), 32'd0);
        check("rst_err",   32'(err_a), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Default 1011, overlapping: 1011011 -> two matches
        add(1,1,1,0,8'h00,4'd0,0, 0,0,0,0);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,1,1);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,1,1);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,1,1);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,2,2);
        // Flush, non-overlapping: 1011011 -> one match, then 1011 -> second
        add(0,0,0,1,8'h0B,4'd4,0, 0,0,2,2);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,2,2);
        add(1,0,0,0,8'h00,4'd0,0, 0,0,2,2);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,2,2);
        add(1,1,0,0,8'h00,4'd0,0, 1,0,3,3);
        add(1,0,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,0,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,1,0,0,8'h00,4'd0,0, 0,0,3,3);
        add(1,1,0,0,8'h00,4'd0,0, 1,0,4,3);
        // Pattern 110 len 3, valid bits interleaved with idle cycles
        add(0,0,1,1,8'h06,4'd3,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(0,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(0,0,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,0,1,0,8'h00,4'd0,0, 1,0,5,3);
        add(0,1,1,0,8'h00,4'd0,0, 0,0,5,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,5,3);
        add(0,0,1,0,8'h00,4'd0,0, 0,0,5,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,5,3);
        add(0,0,1,0,8'h00,4'd0,0, 0,0,5,3);
        add(1,0,1,0,8'h00,4'd0,0, 1,0,6,3);
        // Rejected loads keep config and history; a load drops the bit in its cycle
        add(0,0,1,1,8'hFB,4'd4,0, 0,0,6,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,6,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,6,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,6,3);
        add(0,0,1,1,8'hFF,4'd0,0, 0,1,6,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,7,3);
        add(1,0,1,1,8'hFF,4'd9,0, 0,1,7,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,7,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,7,3);
        add(1,1,1,1,8'hFB,4'd4,0, 0,0,7,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,7,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,7,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,7,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,8,3);
        // Clear coincident with a match wins
        add(1,0,1,0,8'h00,4'd0,0, 0,0,8,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,8,3);
        add(1,1,1,0,8'h00,4'd0,1, 1,0,0,0);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,0,0);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,1,1);
        // len=1: every bit equal to pattern[0] matches in both modes
        add(0,0,0,1,8'h01,4'd1,0, 0,0,1,1);
        add(1,1,0,0,8'h00,4'd0,0, 1,0,2,2);
        add(1,0,0,0,8'h00,4'd0,0, 0,0,2,2);
        add(1,1,0,0,8'h00,4'd0,0, 1,0,3,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,4,3);
        // len=MAX_LEN: 10100101
        add(0,0,1,1,8'hA5,4'd8,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,0,1,0,8'h00,4'd0,0, 0,0,4,3);
        add(1,1,1,0,8'h00,4'd0,0, 1,0,5,3);
        add(0,0,1,0,8'h00,4'd0,1, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset restores the default 1011 config; a pending pulse is dropped at once
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step_bit(1'b1, 1'b0, "drop_b1");
        step_bit(1'b0, 1'b0, "drop_b2");
        step_bit(1'b1, 1'b0, "drop_b3");
        step_bit(1'b1, 1'b1, "drop_b4");
        check("drop_cnt_pre", 32'(cnt_a), 32'd1);
        reset = 1'b1;
        #1;
        check("drop_det", 32'(det_a), 32'd0);
        check("drop_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset between bit 3 and bit 4 of 1011
        step_bit(1'b1, 1'b0, "mid_b1");
        step_bit(1'b0, 1'b0, "mid_b2");
        step_bit(1'b1, 1'b0, "mid_b3");
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_det", 32'(det_a), 32'd0);
        check("mid_rst_err", 32'(err_a), 32'd0);
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step_bit(1'b1, 1'b0, "post_b4");
        step_bit(1'b1, 1'b0, "post_a1");
        step_bit(1'b0, 1'b0, "post_a2");
        step_bit(1'b1, 1'b0, "post_a3");
        step_bit(1'b1, 1'b1, "post_a4");
        check("post_cnt", 32'(cnt_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
